// File: rtl/lzc_pkg.sv
// lzc_pkg: shared types and elaboration-time helpers for the pipelined
// find-first-one unit.
//   lzc_mode_t     search direction (highest or lowest set bit)
//   lzc_idx_w      index width for a given operand width
//   lzc_params_ok  legality of an XLEN/STAGES pair
//   lzc_reg_after  whether a pipeline register follows a given tree level
//   lzc_voff/coff  offsets of each tree level inside the flattened
//                  valid/index vectors used by lzc_pipe
package lzc_pkg;

    typedef enum logic {
        LZC_MSB = 1'b0,
        LZC_LSB = 1'b1
    } lzc_mode_t;

    function automatic int lzc_idx_w(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic bit lzc_params_ok(input int xlen, input int stages);
        int levels;
        levels = $clog2(xlen);
        return (xlen >= 8) && (xlen <= 128) && ((xlen & (xlen - 1)) == 0) &&
               (stages >= 1) && (stages <= levels);
    endfunction

    // Registers sit after level floor(k*L/S)-1, k = 1..S; k = S is always
    // the last level, so the output register is always present.
    function automatic bit lzc_reg_after(input int level, input int levels, input int stages);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k <= stages; k++) begin
            if ((k * levels) / stages - 1 == level) hit = 1'b1;
        end
        return hit;
    endfunction

    // Level k has xlen>>(k+1) nodes, each with a 1-bit flag and a
    // (k+1)-bit index; levels are packed back to back from level 0.
    function automatic int lzc_voff(input int level, input int xlen);
        int s;
        s = 0;
        for (int k = 0; k < level; k++) s += xlen >> (k + 1);
        return s;
    endfunction

    function automatic int lzc_coff(input int level, input int xlen);
        int s;
        s = 0;
        for (int k = 0; k < level; k++) s += (xlen >> (k + 1)) * (k + 1);
        return s;
    endfunction

endpackage

// File: rtl/lzc_node.sv
// lzc_node: one merge node of the find-first-one tree.
//   vh/ch  any-set flag and index of the upper child
//   vl/cl  any-set flag and index of the lower child
//   v/c    merged flag and index, one bit wider than the children
// The upper child wins whenever it holds a set bit, so the tree always
// reports the highest set bit of its (possibly bit-reversed) operand.
module lzc_node #(
    parameter int CW = 1
) (
    input  logic          vh,
    input  logic          vl,
    input  logic [CW-1:0] ch,
    input  logic [CW-1:0] cl,
    output logic          v,
    output logic [CW:0]   c
);
    assign v = vh | vl;
    assign c = vh ? {1'b1, ch} : {1'b0, cl};
endmodule

// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined find-first-one with valid/ready flow control.
//   clock, reset            rising-edge clock, async active-low reset
//   in_valid/in_ready       operand handshake; in_ready = ~stall
//   in_a, in_mode, in_tag   operand, 0 = highest / 1 = lowest set bit, tag
//   out_valid/out_ready     result handshake
//   out_c, out_v, out_tag   index in operand numbering, any-set, tag
// Global-stall pipeline: every stage holds while the output register holds
// an unaccepted result. Bubbles travel with the data and vanish at the
// output because out_valid simply follows the last stage valid bit.
module lzc_pipe
    import lzc_pkg::*;
#(
    parameter int  XLEN   = 64,
    parameter int  STAGES = 2,
    parameter int  TAGW   = 4,
    localparam int LW     = lzc_idx_w(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic            in_mode,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LW-1:0]   out_c,
    output logic            out_v,
    output logic [TAGW-1:0] out_tag
);
    localparam int VTOT  = lzc_voff(LW, XLEN);
    localparam int CTOT  = lzc_coff(LW, XLEN);
    localparam int VLAST = lzc_voff(LW - 1, XLEN);
    localparam int CLAST = lzc_coff(LW - 1, XLEN);

    if (!lzc_params_ok(XLEN, STAGES)) begin : g_bad_params
        $error("lzc_pipe: illegal XLEN/STAGES combination");
    end

    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // LSB search reuses the MSB tree on the mirrored operand.
    logic [XLEN-1:0] a_srch;
    always_comb begin
        a_srch = in_a;
        if (lzc_mode_t'(in_mode) == LZC_LSB) begin
            for (int i = 0; i < XLEN; i++) a_srch[i] = in_a[XLEN-1-i];
        end
    end

    // Per-level outputs after the optional stage register.
    logic [VTOT-1:0] v_lvl;
    logic [CTOT-1:0] c_lvl;
    logic [LW-1:0]   vld_lvl;
    logic [LW-1:0]   mode_lvl;
    logic [TAGW-1:0] tag_lvl [LW];

    for (genvar j = 0; j < LW; j++) begin : g_lvl
        localparam int  N    = XLEN >> (j + 1);
        localparam int  W    = j + 1;
        localparam int  VOFF = lzc_voff(j, XLEN);
        localparam int  COFF = lzc_coff(j, XLEN);
        localparam bit  REG  = lzc_reg_after(j, LW, STAGES);
        localparam bit  LAST = (j == LW - 1);

        logic [N-1:0]    v_d, v_q;
        logic [N*W-1:0]  c_d, c_q;
        logic            vld_d, vld_q;
        logic            mode_d, mode_q;
        logic [TAGW-1:0] tag_d, tag_q;

        if (j == 0) begin : g_leaf
            // Degenerate node over a bit pair: index is just the upper bit.
            for (genvar i = 0; i < N; i++) begin : g_n
                assign v_d[i] = a_srch[2*i+1] | a_srch[2*i];
                assign c_d[i] = a_srch[2*i+1];
            end
            assign vld_d  = in_valid & in_ready;
            assign mode_d = in_mode;
            assign tag_d  = in_tag;
        end else begin : g_inner
            localparam int PVOFF = lzc_voff(j - 1, XLEN);
            localparam int PCOFF = lzc_coff(j - 1, XLEN);
            for (genvar i = 0; i < N; i++) begin : g_n
                lzc_node #(.CW(j)) u_node (
                    .vh (v_lvl[PVOFF + 2*i + 1]),
                    .vl (v_lvl[PVOFF + 2*i]),
                    .ch (c_lvl[PCOFF + (2*i + 1)*j +: j]),
                    .cl (c_lvl[PCOFF + (2*i)*j +: j]),
                    .v  (v_d[i]),
                    .c  (c_d[i*W +: W])
                );
            end
            assign vld_d  = vld_lvl[j-1];
            assign mode_d = mode_lvl[j-1];
            assign tag_d  = tag_lvl[j-1];
        end

        if (LAST) begin : g_out
            // Output register is fully reset so out_* read zero after reset.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    vld_q  <= 1'b0;
                    v_q    <= '0;
                    c_q    <= '0;
                    mode_q <= 1'b0;
                    tag_q  <= '0;
                end else if (adv) begin
                    vld_q  <= vld_d;
                    v_q    <= v_d;
                    c_q    <= c_d;
                    mode_q <= mode_d;
                    tag_q  <= tag_d;
                end
            end
        end else if (REG) begin : g_reg
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) vld_q <= 1'b0;
                else if (adv) vld_q <= vld_d;
            end
            always_ff @(posedge clock) begin
                if (adv) begin
                    v_q    <= v_d;
                    c_q    <= c_d;
                    mode_q <= mode_d;
                    tag_q  <= tag_d;
                end
            end
        end else begin : g_comb
            assign vld_q  = vld_d;
            assign v_q    = v_d;
            assign c_q    = c_d;
            assign mode_q = mode_d;
            assign tag_q  = tag_d;
        end

        assign v_lvl[VOFF +: N]   = v_q;
        assign c_lvl[COFF +: N*W] = c_q;
        assign vld_lvl[j]         = vld_q;
        assign mode_lvl[j]        = mode_q;
        assign tag_lvl[j]         = tag_q;
    end

    logic [LW-1:0] top_c;
    assign top_c     = c_lvl[CLAST +: LW];
    assign out_valid = vld_lvl[LW-1];
    assign out_v     = v_lvl[VLAST];
    assign out_tag   = tag_lvl[LW-1];

    // Mirrored index i maps back to XLEN-1-i, which is ~i for a power of
    // two; an empty operand reports index 0 in either mode.
    always_comb begin
        out_c = '0;
        if (out_v) begin
            out_c = (lzc_mode_t'(mode_lvl[LW-1]) == LZC_LSB) ? ~top_c : top_c;
        end
    end

endmodule

// File: tb/tb_lzc_pipe.sv
// tb_lzc_pipe: directed checks of lzc_pipe at XLEN=64/STAGES=2, plus
// sweep instances at XLEN=8/STAGES=3, XLEN=32/STAGES=1, XLEN=128/STAGES=7.
module tb_lzc_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic        in_mode = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_c;
    logic        out_v;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    lzc_pipe #(.XLEN(64), .STAGES(2), .TAGW(4)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_v(out_v), .out_tag(out_tag)
    );

    // Sweep instances share operand/mode; each has its own valid.
    logic [127:0] sw_a = '0;
    logic         sw_mode = 1'b0;
    logic [2:0]   sw_valid = '0;
    logic [2:0]   sw_irdy, sw_ovalid, sw_ov;
    logic [2:0]   c8;
    logic [4:0]   c32;
    logic [6:0]   c128;
    logic [3:0]   t8, t32, t128;

    lzc_pipe #(.XLEN(8), .STAGES(3), .TAGW(4)) u_d8 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid[0]), .in_ready(sw_irdy[0]), .in_a(sw_a[7:0]),
        .in_mode(sw_mode), .in_tag(4'h0),
        .out_valid(sw_ovalid[0]), .out_ready(1'b1),
        .out_c(c8), .out_v(sw_ov[0]), .out_tag(t8)
    );

    lzc_pipe #(.XLEN(32), .STAGES(1), .TAGW(4)) u_d32 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid[1]), .in_ready(sw_irdy[1]), .in_a(sw_a[31:0]),
        .in_mode(sw_mode), .in_tag(4'h0),
        .out_valid(sw_ovalid[1]), .out_ready(1'b1),
        .out_c(c32), .out_v(sw_ov[1]), .out_tag(t32)
    );

    lzc_pipe #(.XLEN(128), .STAGES(7), .TAGW(4)) u_d128 (
        .clock(clock), .reset(reset),
        .in_valid(sw_valid[2]), .in_ready(sw_irdy[2]), .in_a(sw_a),
        .in_mode(sw_mode), .in_tag(4'h0),
        .out_valid(sw_ovalid[2]), .out_ready(1'b1),
        .out_c(c128), .out_v(sw_ov[2]), .out_tag(t128)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan model: MSB keeps the last set bit seen, LSB the first.
    function automatic logic [6:0] ref_c(input logic [127:0] a, input bit mode, input int xlen);
        logic [6:0] r;
        bit found;
        r = '0;
        found = 1'b0;
        for (int i = 0; i < xlen; i++) begin
            if (a[i]) begin
                if (!mode || !found) r = 7'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic send_one(input string name, input logic [63:0] a, input bit mode,
                            input logic [3:0] tag, input logic [5:0] exp_c, input bit exp_v);
        int lat;
        bit seen;
        @(negedge clock);
        in_a = a; in_mode = mode; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            in_valid = 1'b0;
            seen = out_valid;
        end
        check({name, "_lat"}, 128'(lat), 128'd2);
        check({name, "_c"}, 128'(out_c), 128'(exp_c));
        check({name, "_v"}, 128'(out_v), 128'(exp_v));
        check({name, "_tag"}, 128'(out_tag), 128'(tag));
    endtask

    task automatic sweep_one(input int k, input int stages, input int xlen,
                             input logic [127:0] a, input bit mode);
        int lat;
        bit seen;
        logic [6:0] oc;
        logic ov;
        @(negedge clock);
        sw_a = a; sw_mode = mode; sw_valid[k] = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < stages + 4) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            sw_valid = '0;
            seen = sw_ovalid[k];
        end
        case (k)
            0:       begin oc = 7'(c8);  ov = sw_ov[0]; end
            1:       begin oc = 7'(c32); ov = sw_ov[1]; end
            default: begin oc = c128;    ov = sw_ov[2]; end
        endcase
        check($sformatf("sw%0d_lat", xlen), 128'(lat), 128'(stages));
        check($sformatf("sw%0d_c_%0h_m%0d", xlen, a, mode), 128'(oc), 128'(ref_c(a, mode, xlen)));
        check($sformatf("sw%0d_v", xlen), 128'(ov), 128'(|a));
    endtask

    logic [63:0] s_a   [16];
    bit          s_m   [16];
    logic [5:0]  s_exp [16];

    initial begin
        int idx, got;
        bit prev_stall;
        logic [5:0] held_c;
        logic [3:0] held_tag;
        logic held_v;

        // Reset state
        #12;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_c", 128'(out_c), 128'd0);
        check("rst_out_v", 128'(out_v), 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // Directed vectors (mode 0 = MSB, 1 = LSB)
        send_one("msb_bit0",  64'h0000_0000_0000_0001, 1'b0, 4'h1, 6'd0,  1'b1);
        send_one("msb_bit63", 64'h8000_0000_0000_0000, 1'b0, 4'h2, 6'd63, 1'b1);
        send_one("lsb_mix",   64'h0000_0100_0000_F000, 1'b1, 4'h3, 6'd12, 1'b1);
        send_one("msb_mix",   64'h0000_0100_0000_F000, 1'b0, 4'h4, 6'd40, 1'b1);
        send_one("msb_zero",  64'h0,                   1'b0, 4'hA, 6'd0,  1'b0);
        send_one("lsb_zero",  64'h0,                   1'b1, 4'h5, 6'd0,  1'b0);
        send_one("lsb_ones",  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'h6, 6'd0,  1'b1);
        send_one("msb_ones",  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'h7, 6'd63, 1'b1);
        send_one("lsb_bit63", 64'h8000_0000_0000_0000, 1'b1, 4'h8, 6'd63, 1'b1);
        send_one("lsb_bit0",  64'h0000_0000_0000_0001, 1'b1, 4'h9, 6'd0,  1'b1);

        // Streaming with random back-pressure
        for (int i = 0; i < 16; i++) begin
            s_a[i] = (64'h1 << (i * 4)) | (64'h1 << ((i * 7 + 3) % 64));
            s_m[i] = i[0];
            s_exp[i] = ref_c({64'h0, s_a[i]}, s_m[i], 64)[5:0];
        end
        idx = 0;
        got = 0;
        prev_stall = 1'b0;
        held_c = '0; held_tag = '0; held_v = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            @(negedge clock);
            if (prev_stall) begin
                check("stall_valid", 128'(out_valid), 128'd1);
                check("stall_c", 128'(out_c), 128'(held_c));
                check("stall_v", 128'(out_v), 128'(held_v));
                check("stall_tag", 128'(out_tag), 128'(held_tag));
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (idx < 16);
            if (idx < 16) begin
                in_a = s_a[idx]; in_mode = s_m[idx]; in_tag = 4'(idx);
            end
            #1;
            if (prev_stall) check("stall_in_ready", 128'(in_ready), 128'(out_ready));
            if (out_valid && out_ready) begin
                check($sformatf("stream_tag%0d", got), 128'(out_tag), 128'(got));
                check($sformatf("stream_c%0d", got), 128'(out_c), 128'(s_exp[got]));
                check($sformatf("stream_v%0d", got), 128'(out_v), 128'd1);
                got++;
            end
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !out_ready;
            held_c = out_c; held_tag = out_tag; held_v = out_v;
        end
        check("stream_count", 128'(got), 128'd16);
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("stream_nodup", 128'(out_valid), 128'd0);

        // Full pipe held by out_ready = 0
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 64'h0000_0000_0000_0010; in_mode = 1'b0; in_tag = 4'h1;
        #1;
        check("full_rdy_a", 128'(in_ready), 128'd1);
        @(posedge clock);
        @(negedge clock);
        in_a = 64'h0000_0000_0010_0000; in_tag = 4'h2;
        #1;
        check("full_rdy_b", 128'(in_ready), 128'd1);
        @(posedge clock);
        @(negedge clock);
        in_a = 64'hFFFF_0000_0000_0000; in_tag = 4'h3;
        repeat (3) begin
            #1;
            check("full_in_ready", 128'(in_ready), 128'd0);
            check("full_out_valid", 128'(out_valid), 128'd1);
            check("full_out_tag", 128'(out_tag), 128'd1);
            @(posedge clock);
            @(negedge clock);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        check("drain0_valid", 128'(out_valid), 128'd1);
        check("drain0_tag", 128'(out_tag), 128'd1);
        check("drain0_c", 128'(out_c), 128'd4);
        @(posedge clock);
        @(negedge clock);
        check("drain1_valid", 128'(out_valid), 128'd1);
        check("drain1_tag", 128'(out_tag), 128'd2);
        check("drain1_c", 128'(out_c), 128'd20);
        @(posedge clock);
        @(negedge clock);
        check("drain_empty", 128'(out_valid), 128'd0);

        // Reset with two results in flight
        out_ready = 1'b1; in_valid = 1'b1;
        in_a = 64'h0000_0000_0000_0100; in_mode = 1'b0; in_tag = 4'h5;
        @(posedge clock);
        @(negedge clock);
        in_tag = 4'h6;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        check("pre_rst_valid", 128'(out_valid), 128'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_c", 128'(out_c), 128'd0);
        check("mid_rst_v", 128'(out_v), 128'd0);
        check("mid_rst_tag", 128'(out_tag), 128'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("post_rst_stale", 128'(out_valid), 128'd0);
        end
        check("post_rst_ready", 128'(in_ready), 128'd1);
        send_one("post_rst", 64'h0000_0000_8000_0000, 1'b1, 4'hC, 6'd31, 1'b1);

        // Sweeps against the scan model
        for (int x = 0; x < 256; x++) begin
            sweep_one(0, 3, 8, 128'(x), 1'b0);
            sweep_one(0, 3, 8, 128'(x), 1'b1);
        end
        for (int n = 0; n < 32; n++) begin
            sweep_one(1, 1, 32, 128'(32'h1 << n), 1'(n));
            sweep_one(1, 1, 32, 128'($urandom), 1'(n >> 1));
        end
        for (int n = 0; n < 128; n++) begin
            sweep_one(2, 7, 128, 128'h1 << n, 1'b0);
            sweep_one(2, 7, 128, 128'h1 << n, 1'b1);
        end
        for (int n = 0; n < 20; n++) begin
            sweep_one(2, 7, 128, {$urandom, $urandom, $urandom, $urandom}, 1'(n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
